ysyx_040750_lsu_axi_master: RTL and testbench
=============================================

Name: ysyx_040750_lsu_axi_master

Overview:
- AXI-lite-style initiator between the memory stage of the pipeline and memory-mapped devices (CLINT, UART, data RAM bridge).
- Accepts one load/store request at a time over a valid/ready port.
- Generates lane-aligned write data and wstrb, and drives the AR/R or AW/W/B channels.
- For loads, extracts, sign/zero-extends and returns data; for stores, returns completion.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, bus data width; wstrb width is DATA_W/8.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset
- I_req_valid  in  1  request valid
- O_req_ready  out  1  block idle, can accept a request
- I_req_we  in  1  1=store, 0=load
- I_req_addr  in  32  byte address
- I_req_size  in  2  0=byte, 1=half, 2=word, 3=dword
- I_req_signed  in  1  sign-extend load result
- I_req_wdata  in  64  store data, right-justified (bit 0 = LSB of datum)
- O_rsp_valid  out  1  one-cycle completion pulse
- O_rsp_rdata  out  64  extended load data; 0 for stores
- O_araddr  out  32
- O_arvalid  out  1
- I_arready  in  1
- I_rdata  in  64
- I_rvalid  in  1
- O_rready  out  1
- O_awaddr  out  32
- O_awvalid  out  1
- I_awready  in  1
- O_wdata  out  64
- O_wstrb  out  8
- O_wvalid  out  1
- I_wready  in  1
- I_bvalid  in  1
- O_bready  out  1

Behaviour:
- Reset: I_rst, synchronous, active-high; clock I_clk.
  - State goes to IDLE.
  - All valid/ready outputs are 0; O_rsp_rdata=0; address and data registers are 0.
  - Reset mid-transaction aborts it: every valid drops the next cycle and no response is issued.
- FSM states: IDLE, AR, R, AW, W, B, RSP.
- IDLE:
  - O_req_ready=1.
  - On I_req_valid, register addr, size, signed, we, shifted wdata and wstrb.
  - Go to AW if we=1, else AR.
- Store-side lane generation:
  - off = addr[2:0].
  - wdata is shifted left by 8*off.
  - wstrb = ((1<<(1<<size))-1) << off, truncated to 8 bits.
  - Misaligned requests (off not a multiple of 2^size) are not checked; the truncated strobe is issued as-is.
- AR:
  - O_arvalid=1 and O_araddr = registered addr, held stable until I_arready.
  - Handshake goes to R.
- R:
  - O_rready=1.
  - On I_rvalid, capture I_rdata >> (8*off).
  - Truncate to size, then sign- or zero-extend per signed.
  - Go to RSP.
- AW:
  - O_awvalid=1 and O_awaddr = addr, held until I_awready.
  - Handshake goes to W.
  - O_wvalid must never be asserted in the same cycle as, or before, the AW handshake: devices latch address decode on the AW handshake.
- W:
  - O_wvalid=1; O_wdata and O_wstrb held stable; O_bready=1.
  - On W handshake: if I_bvalid is also high that cycle, go to RSP; otherwise go to B.
  - Devices may assert bvalid in the same cycle as the W handshake, so this case must be accepted.
- B:
  - O_bready=1.
  - On I_bvalid, go to RSP.
- RSP:
  - O_rsp_valid=1 for exactly one cycle; O_rsp_rdata valid that cycle.
  - Go to IDLE.
  - No backpressure on the response.
- Latency with always-ready slaves:
  - Load: accept at cycle 0, AR at 1, R at 2 (rvalid is one cycle after AR), rsp at 3.
  - Store: accept at cycle 0, AW at 1, W+B at 2, rsp at 3.
- Outputs are registered or decoded directly from state; there is no combinational path from I_req_* to AXI outputs.
- Once a valid is asserted it is never withdrawn before its handshake, except on reset.
- Unexpected I_rvalid/I_bvalid in other states is ignored.

Decomposition:
- Shared package/header holds the FSM state encodings (3-bit) and the size codes SZ_B/SZ_H/SZ_W/SZ_D.
- One sub-module, ysyx_040750_lsu_lane: purely combinational.
  - Store side: size + offset -> wstrb, shifted wdata.
  - Load side: rdata + offset + size + signed -> extended result.
- The FSM lives in the top module.

Test Plan:
- Load dword, always-ready slave returning 64'h0123_4567_89AB_CDEF:
  - arvalid at cycle 1 with araddr 0x0200BFF8.
  - rsp_valid at cycle 3 with rdata 0x0123456789ABCDEF.
- Load signed byte at addr 0x80000005, rdata 64'h0000_8000_0000_0000 -> rsp_rdata 0xFFFFFFFFFFFFFF80. Same load with signed=0 -> 0x80.
- Store word 0xDEADBEEF to 0x02004004:
  - awvalid cycle 1; wvalid only from cycle 2 onward.
  - wstrb 8'hF0, wdata 0xDEADBEEF_00000000.
  - bvalid is asserted in the W-handshake cycle -> rsp_valid at cycle 3.
- Slave stalls (arready low 3 cycles, rvalid 2 cycles late):
  - araddr and arvalid stay stable throughout.
  - O_req_ready stays 0 until the response.
  - Exactly one rsp_valid pulse.
- bvalid delayed 4 cycles after the W handshake:
  - FSM waits in B with bready=1.
  - Single rsp pulse after bvalid.
- I_rst asserted while in W:
  - Next cycle all valids=0 and O_req_ready=1.
  - No rsp_valid is issued.
  - A following load completes normally.

Source files
------------

// File: rtl/ysyx_040750_lsu_axi_master_pkg.sv
// Shared definitions for the LSU AXI-lite initiator: widths, size codes,
// FSM encoding and the per-state channel control decode.
package ysyx_040750_lsu_axi_master_pkg;

  localparam int unsigned LSU_ADDR_W = 32;
  localparam int unsigned LSU_DATA_W = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_RSP  = 3'd6
  } lsu_state_e;

  typedef struct packed {
    logic req_ready;
    logic arvalid;
    logic rready;
    logic awvalid;
    logic wvalid;
    logic bready;
    logic rsp_valid;
  } lsu_ctl_t;

  // Handshake outputs asserted while the FSM sits in a given state.
  function automatic lsu_ctl_t ctl_of(input lsu_state_e st);
    lsu_ctl_t c;
    c = '0;
    case (st)
      ST_IDLE: c.req_ready = 1'b1;
      ST_AR:   c.arvalid   = 1'b1;
      ST_R:    c.rready    = 1'b1;
      ST_AW:   c.awvalid   = 1'b1;
      ST_W: begin
        c.wvalid = 1'b1;
        c.bready = 1'b1;
      end
      ST_B:    c.bready    = 1'b1;
      ST_RSP:  c.rsp_valid = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_040750_lsu_lane.sv
// Byte-lane steering: store data/strobe placement and load extraction with
// sign/zero extension. Purely combinational.
module ysyx_040750_lsu_lane
  import ysyx_040750_lsu_axi_master_pkg::*;
#(
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic [1:0]                    I_st_size,
  input  logic [$clog2(DATA_W/8)-1:0]   I_st_off,
  input  logic [DATA_W-1:0]             I_st_wdata,
  output logic [DATA_W-1:0]             O_st_wdata_c,
  output logic [DATA_W/8-1:0]           O_st_wstrb_c,
  input  logic [DATA_W-1:0]             I_ld_rdata,
  input  logic [$clog2(DATA_W/8)-1:0]   I_ld_off,
  input  logic [1:0]                    I_ld_size,
  input  logic                          I_ld_sgn,
  output logic [DATA_W-1:0]             O_ld_data_c
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [3:0]        nbytes;
  logic [STRB_W-1:0] mask;
  logic [DATA_W-1:0] shifted;

  // Strobe covers 2^size bytes starting at the offset; lanes past the top drop off.
  always_comb begin
    nbytes = 4'd1 << I_st_size;
    mask   = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      mask[i] = (i < 32'(nbytes));
    end
    O_st_wstrb_c = mask << I_st_off;
    O_st_wdata_c = I_st_wdata << {I_st_off, 3'b000};
  end

  always_comb begin
    shifted = I_ld_rdata >> {I_ld_off, 3'b000};
    case (I_ld_size)
      SZ_B:    O_ld_data_c = {{(DATA_W-8){I_ld_sgn & shifted[7]}},   shifted[7:0]};
      SZ_H:    O_ld_data_c = {{(DATA_W-16){I_ld_sgn & shifted[15]}}, shifted[15:0]};
      SZ_W:    O_ld_data_c = {{(DATA_W-32){I_ld_sgn & shifted[31]}}, shifted[31:0]};
      default: O_ld_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_040750_lsu_axi_master.sv
// LSU AXI-lite initiator: one outstanding load or store, lane-aligned writes,
// extended load data, single-cycle completion pulse.
module ysyx_040750_lsu_axi_master
  import ysyx_040750_lsu_axi_master_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_req_valid,
  output logic                O_req_ready,
  input  logic                I_req_we,
  input  logic [ADDR_W-1:0]   I_req_addr,
  input  logic [1:0]          I_req_size,
  input  logic                I_req_signed,
  input  logic [DATA_W-1:0]   I_req_wdata,
  output logic                O_rsp_valid,
  output logic [DATA_W-1:0]   O_rsp_rdata,
  output logic [ADDR_W-1:0]   O_araddr,
  output logic                O_arvalid,
  input  logic                I_arready,
  input  logic [DATA_W-1:0]   I_rdata,
  input  logic                I_rvalid,
  output logic                O_rready,
  output logic [ADDR_W-1:0]   O_awaddr,
  output logic                O_awvalid,
  input  logic                I_awready,
  output logic [DATA_W-1:0]   O_wdata,
  output logic [DATA_W/8-1:0] O_wstrb,
  output logic                O_wvalid,
  input  logic                I_wready,
  input  logic                I_bvalid,
  output logic                O_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  lsu_state_e          state_q, state_d;
  lsu_ctl_t            ctl_q, ctl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   st_wdata_c;
  logic [STRB_W-1:0]   st_wstrb_c;
  logic [DATA_W-1:0]   ld_data_c;

  ysyx_040750_lsu_lane #(
    .DATA_W (DATA_W)
  ) u_lane (
    .I_st_size    (I_req_size),
    .I_st_off     (I_req_addr[OFF_W-1:0]),
    .I_st_wdata   (I_req_wdata),
    .O_st_wdata_c (st_wdata_c),
    .O_st_wstrb_c (st_wstrb_c),
    .I_ld_rdata   (I_rdata),
    .I_ld_off     (addr_q[OFF_W-1:0]),
    .I_ld_size    (size_q),
    .I_ld_sgn     (sgn_q),
    .O_ld_data_c  (ld_data_c)
  );

  // Next-state and datapath capture; every handshake waits on the state's own valid.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (I_req_valid) begin
          addr_d  = I_req_addr;
          size_d  = I_req_size;
          sgn_d   = I_req_signed;
          wdata_d = st_wdata_c;
          wstrb_d = st_wstrb_c;
          rdata_d = '0;
          state_d = I_req_we ? ST_AW : ST_AR;
        end
      end
      ST_AR:  if (I_arready) state_d = ST_R;
      ST_R: begin
        if (I_rvalid) begin
          rdata_d = ld_data_c;
          state_d = ST_RSP;
        end
      end
      ST_AW:  if (I_awready) state_d = ST_W;
      // A slave may return B in the same cycle it takes W.
      ST_W:   if (I_wready) state_d = I_bvalid ? ST_RSP : ST_B;
      ST_B:   if (I_bvalid) state_d = ST_RSP;
      ST_RSP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ctl_d = ctl_of(state_d);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
      ctl_q   <= ctl_of(ST_IDLE);
      addr_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  assign O_req_ready = ctl_q.req_ready;
  assign O_arvalid   = ctl_q.arvalid;
  assign O_rready    = ctl_q.rready;
  assign O_awvalid   = ctl_q.awvalid;
  assign O_wvalid    = ctl_q.wvalid;
  assign O_bready    = ctl_q.bready;
  assign O_rsp_valid = ctl_q.rsp_valid;
  assign O_rsp_rdata = rdata_q;
  assign O_araddr    = addr_q;
  assign O_awaddr    = addr_q;
  assign O_wdata     = wdata_q;
  assign O_wstrb     = wstrb_q;

endmodule

// File: tb/tb_ysyx_040750_lsu_axi_master.sv
// Self-checking bench: the bench plays the AXI slave over a byte-addressed
// memory model and predicts load results and write lanes from that model.
module tb_ysyx_040750_lsu_axi_master;

  logic        I_clk;
  logic        I_rst;
  logic        I_req_valid;
  logic        O_req_ready;
  logic        I_req_we;
  logic [31:0] I_req_addr;
  logic [1:0]  I_req_size;
  logic        I_req_signed;
  logic [63:0] I_req_wdata;
  logic        O_rsp_valid;
  logic [63:0] O_rsp_rdata;
  logic [31:0] O_araddr;
  logic        O_arvalid;
  logic        I_arready;
  logic [63:0] I_rdata;
  logic        I_rvalid;
  logic        O_rready;
  logic [31:0] O_awaddr;
  logic        O_awvalid;
  logic        I_awready;
  logic [63:0] O_wdata;
  logic [7:0]  O_wstrb;
  logic        O_wvalid;
  logic        I_wready;
  logic        I_bvalid;
  logic        O_bready;

  ysyx_040750_lsu_axi_master dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_req_valid  (I_req_valid),
    .O_req_ready  (O_req_ready),
    .I_req_we     (I_req_we),
    .I_req_addr   (I_req_addr),
    .I_req_size   (I_req_size),
    .I_req_signed (I_req_signed),
    .I_req_wdata  (I_req_wdata),
    .O_rsp_valid  (O_rsp_valid),
    .O_rsp_rdata  (O_rsp_rdata),
    .O_araddr     (O_araddr),
    .O_arvalid    (O_arvalid),
    .I_arready    (I_arready),
    .I_rdata      (I_rdata),
    .I_rvalid     (I_rvalid),
    .O_rready     (O_rready),
    .O_awaddr     (O_awaddr),
    .O_awvalid    (O_awvalid),
    .I_awready    (I_awready),
    .O_wdata      (O_wdata),
    .O_wstrb      (O_wstrb),
    .O_wvalid     (O_wvalid),
    .I_wready     (I_wready),
    .I_bvalid     (I_bvalid),
    .O_bready     (O_bready)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int total;
  int bad;
  logic [7:0]  mem [0:63];
  int          t_rsp_at, t_ar_first, t_aw_first, t_w_first;
  logic [63:0] t_rd, t_wd;
  logic [7:0]  t_ws;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic set_dword(input int idx, input logic [63:0] v);
    for (int k = 0; k < 8; k++) mem[8*idx + k] = v[8*k +: 8];
  endtask

  function automatic logic [63:0] dword_at(input logic [31:0] a);
    logic [63:0] v;
    int base;
    base = 8 * int'(a[5:3]);
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[base + k];
    return v;
  endfunction

  // Load value: 2^size bytes from the offset (bytes past the dword read as 0), then extend.
  function automatic logic [63:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    logic [63:0] v;
    int n, off, base;
    n = 1 << sz;
    off = int'(a[2:0]);
    base = 8 * int'(a[5:3]);
    v = '0;
    for (int k = 0; k < n; k++) if (off + k < 8) v[8*k +: 8] = mem[base + off + k];
    if (sgn && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic [31:0] a, input logic [1:0] sz);
    logic [7:0] s;
    int n, off;
    n = 1 << sz;
    off = int'(a[2:0]);
    s = '0;
    for (int k = 0; k < n; k++) if (off + k < 8) s[off + k] = 1'b1;
    return s;
  endfunction

  task automatic slave_idle();
    I_arready = 1'b0; I_rvalid = 1'b0; I_awready = 1'b0; I_wready = 1'b0; I_bvalid = 1'b0;
  endtask

  // One request, bench acting as slave with the given stall counts; cycle 0 = accept.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sgn, input logic [63:0] wd, input int ar_wait,
                         input int r_wait, input int aw_wait, input int w_wait, input int b_wait);
    logic [63:0] exp_rd, exp_wd;
    logic [7:0]  exp_st;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, pulses, base;
    bit ar_done, r_done, aw_done, w_done, b_done;
    exp_rd = we ? 64'd0 : model_load(addr, sz, sgn);
    exp_wd = wd << (8 * int'(addr[2:0]));
    exp_st = model_strb(addr, sz);
    base = 8 * int'(addr[5:3]);
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; pulses = 0;
    ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
    t_rsp_at = -1; t_ar_first = -1; t_aw_first = -1; t_w_first = -1;
    t_rd = '0; t_wd = '0; t_ws = '0;
    chk_eq("req_ready_idle", 64'(O_req_ready), 64'd1);
    I_req_valid = 1'b1; I_req_we = we; I_req_addr = addr;
    I_req_size = sz; I_req_signed = sgn; I_req_wdata = wd;
    tick();
    I_req_valid = 1'b0;
    I_req_we = 1'($urandom_range(0, 1));
    I_req_addr = $urandom;
    I_req_size = 2'($urandom_range(0, 3));
    I_req_signed = 1'($urandom_range(0, 1));
    I_req_wdata = {$urandom, $urandom};
    for (int c = 1; c <= 80; c++) begin
      if (t_rsp_at >= 0 && c > t_rsp_at + 1) break;
      slave_idle();
      I_rdata = {$urandom, $urandom};
      if (we) I_rvalid = 1'($urandom_range(0, 1));
      if (!we) I_bvalid = 1'($urandom_range(0, 1));
      if (!we && !ar_done) I_rvalid = 1'($urandom_range(0, 1));
      if (we && !aw_done) I_bvalid = 1'($urandom_range(0, 1));
      if (t_rsp_at < 0) chk_eq("req_ready_busy", 64'(O_req_ready), 64'd0);
      if (O_rsp_valid) begin
        pulses++;
        if (t_rsp_at < 0) begin
          t_rsp_at = c;
          t_rd = O_rsp_rdata;
          chk_eq("rsp_rdata", O_rsp_rdata, exp_rd);
        end
      end
      if (t_rsp_at >= 0 && c == t_rsp_at + 1)
        chk_eq("idle_after_rsp", 64'({O_req_ready, O_rsp_valid}), 64'(2'b10));
      if (!we && ar_done && !r_done) begin
        r_cnt++;
        I_rvalid = 1'b0;
        if (r_cnt > r_wait) begin
          I_rvalid = 1'b1;
          I_rdata = dword_at(addr);
          if (O_rready) r_done = 1;
        end
      end
      if (!we && O_arvalid) begin
        if (t_ar_first < 0) t_ar_first = c;
        chk_eq("araddr", 64'(O_araddr), 64'(addr));
        if (ar_cnt >= ar_wait) begin I_arready = 1'b1; ar_done = 1; end
        ar_cnt++;
      end
      if (we && w_done && !b_done) begin
        b_cnt++;
        if (b_cnt >= b_wait) begin
          I_bvalid = 1'b1;
          if (O_bready) b_done = 1;
        end else begin
          chk_eq("bready_wait", 64'(O_bready), 64'd1);
        end
      end
      if (we && O_wvalid && !w_done) begin
        if (t_w_first < 0) begin
          t_w_first = c;
          chk_eq("w_after_aw", 64'(aw_done), 64'd1);
        end
        if (w_cnt >= w_wait) begin
          I_wready = 1'b1;
          w_done = 1;
          t_wd = O_wdata;
          t_ws = O_wstrb;
          chk_eq("wdata", O_wdata, exp_wd);
          chk_eq("wstrb", 64'(O_wstrb), 64'(exp_st));
          for (int k = 0; k < 8; k++) if (exp_st[k]) mem[base + k] = exp_wd[8*k +: 8];
          if (b_wait == 0) begin I_bvalid = 1'b1; b_done = 1; end
        end
        w_cnt++;
      end
      if (we && O_awvalid) begin
        if (t_aw_first < 0) t_aw_first = c;
        chk_eq("awaddr", 64'(O_awaddr), 64'(addr));
        if (aw_cnt >= aw_wait) begin I_awready = 1'b1; aw_done = 1; end
        aw_cnt++;
      end
      tick();
    end
    slave_idle();
    chk_eq("rsp_pulses", 64'(pulses), 64'd1);
  endtask

  initial begin
    int seen;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    total = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    I_rst = 1'b1;
    I_req_valid = 1'b0; I_req_we = 1'b0; I_req_addr = '0; I_req_size = '0;
    I_req_signed = 1'b0; I_req_wdata = '0; I_rdata = '0;
    slave_idle();
    tick();
    tick();
    chk_eq("rst_req_ready", 64'(O_req_ready), 64'd1);
    chk_eq("rst_valids", 64'({O_arvalid, O_rready, O_awvalid, O_wvalid, O_bready, O_rsp_valid}), 64'd0);
    chk_eq("rst_regs", {O_araddr, O_wstrb, 24'd0}, 64'd0);
    chk_eq("rst_rdata", O_rsp_rdata, 64'd0);
    I_rst = 1'b0;
    tick();

    set_dword(7, 64'h0123_4567_89AB_CDEF);
    run_txn(1'b0, 32'h0200_BFF8, 2'd3, 1'b0, 64'd0, 0, 0, 0, 0, 0);
    chk_eq("ld_d_ar_cycle", 64'(t_ar_first), 64'd1);
    chk_eq("ld_d_rsp_cycle", 64'(t_rsp_at), 64'd3);
    chk_eq("ld_d_data", t_rd, 64'h0123_4567_89AB_CDEF);

    set_dword(0, 64'h0000_8000_0000_0000);
    run_txn(1'b0, 32'h8000_0005, 2'd0, 1'b1, 64'd0, 0, 0, 0, 0, 0);
    chk_eq("ld_sb", t_rd, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(1'b0, 32'h8000_0005, 2'd0, 1'b0, 64'd0, 0, 0, 0, 0, 0);
    chk_eq("ld_ub", t_rd, 64'h0000_0000_0000_0080);

    run_txn(1'b1, 32'h0200_4004, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 0, 0);
    chk_eq("st_w_aw_cycle", 64'(t_aw_first), 64'd1);
    chk_eq("st_w_w_cycle", 64'(t_w_first), 64'd2);
    chk_eq("st_w_wstrb", 64'(t_ws), 64'hF0);
    chk_eq("st_w_wdata", t_wd, 64'hDEAD_BEEF_0000_0000);
    chk_eq("st_w_rsp_cycle", 64'(t_rsp_at), 64'd3);
    chk_eq("st_w_rdata", t_rd, 64'd0);
    run_txn(1'b0, 32'h0200_4004, 2'd2, 1'b1, 64'd0, 0, 0, 0, 0, 0);
    chk_eq("ld_w_back", t_rd, 64'hFFFF_FFFF_DEAD_BEEF);

    run_txn(1'b0, 32'h0200_0010, 2'd3, 1'b0, 64'd0, 3, 2, 0, 0, 0);
    chk_eq("stall_ar_first", 64'(t_ar_first), 64'd1);
    chk_eq("stall_rsp_cycle", 64'(t_rsp_at), 64'd8);

    run_txn(1'b1, 32'h1000_0003, 2'd0, 1'b0, 64'h55, 0, 0, 0, 0, 4);
    chk_eq("bdelay_rsp_cycle", 64'(t_rsp_at), 64'd7);

    // Reset while the write data phase is stalled.
    I_req_valid = 1'b1; I_req_we = 1'b1; I_req_addr = 32'h1000_0010;
    I_req_size = 2'd3; I_req_wdata = 64'hA5A5_A5A5_5A5A_5A5A;
    tick();
    I_req_valid = 1'b0;
    chk_eq("rst_test_aw", 64'(O_awvalid), 64'd1);
    I_awready = 1'b1;
    tick();
    I_awready = 1'b0;
    chk_eq("rst_test_in_w", 64'(O_wvalid), 64'd1);
    I_rst = 1'b1;
    tick();
    I_rst = 1'b0;
    chk_eq("rst_mid_valids", 64'({O_arvalid, O_rready, O_awvalid, O_wvalid, O_bready, O_rsp_valid}), 64'd0);
    chk_eq("rst_mid_ready", 64'(O_req_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (O_rsp_valid) seen++;
      I_wready = 1'($urandom_range(0, 1));
      I_bvalid = 1'($urandom_range(0, 1));
      tick();
    end
    slave_idle();
    chk_eq("rst_no_rsp", 64'(seen), 64'd0);
    run_txn(1'b0, 32'h1000_0010, 2'd3, 1'b0, 64'd0, 0, 0, 0, 0, 0);
    chk_eq("post_rst_rsp_cycle", 64'(t_rsp_at), 64'd3);

    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = {$urandom_range(0, 3) == 0 ? 8'h02 : 8'h80, 18'($urandom), 6'($urandom)};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      run_txn(we, a, sz, 1'($urandom_range(0, 1)), {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
